id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Registered, parametrised RV32I decode stage. Sits between the instruction-fetch pipe register and ex.
//  Drives the register-file read addresses combinationally and samples rs1_data/rs2_data.
//  Decodes the instruction and registers op1/op2/imm/control behind a valid/ready handshake.
//  Supports flush and backpressure hold, and flags illegal instructions.
// PARAMETERS
//  XLEN       32  datapath width (32 or 64); immediates sign-extended to XLEN
//  RADDR_W    5   register address width
//  OH_W       7   width of the operation code handed to ex
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst           in   1        synchronous, active-high reset
//  flush         in   1        kill stage contents (branch/jump redirect)
//  in_valid      in   1        fetch offers in_ins/in_ins_addr
//  in_ready      out  1        stage accepts this cycle
//  in_ins        in   32       instruction word
//  in_ins_addr   in   XLEN     instruction address (pc)
//  rs1_addr      out  RADDR_W  regfile read addr 1 (combinational from in_ins)
//  rs2_addr      out  RADDR_W  regfile read addr 2 (combinational from in_ins)
//  rs1_data      in   XLEN     regfile read data 1, same cycle
//  rs2_data      in   XLEN     regfile read data 2, same cycle
//  out_valid     out  1        decoded bundle valid to ex
//  out_ready     in   1        ex accepts bundle
//  out_op1       out  XLEN     operand 1
//  out_op2       out  XLEN     operand 2
//  out_imm       out  XLEN     sign-extended immediate for the instruction's format
//  out_ins       out  32       instruction word passthrough
//  out_ins_addr  out  XLEN     pc passthrough
//  out_rd_addr   out  RADDR_W  destination register
//  out_rd_wen    out  1        destination write enable
//  out_oh        out  OH_W     operation code
//  out_illegal   out  1        unsupported opcode/funct combination
//  wb_wen/wb_addr/wb_data  in 1/RADDR_W/XLEN  writeback bypass, present only with ID_BYPASS_EN
// BEHAVIOUR
//  - Reset: out_valid=0. All out_* data fields = 0. in_ready=1 after reset.
//  - in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
//  - Latency 1: on accept, decode is registered and out_valid=1 next cycle.
//    With no accept and out_ready=1, out_valid clears.
//  - Hold: out_valid & !out_ready -> every out_* field stable, no accept.
//  - Flush (priority over accept): out_valid<=0 next cycle, input not captured, in_ready=0 while flush=1.
//  - rst takes priority over flush.
//  - Field extraction:
//    - opcode=ins[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7=[31:25].
//  - oh codes:
//    - Upper/jump: LUI=1 AUIPC=2 JAL=3 JALR=4.
//    - Branch: BEQ=5 BNE=6 BLT=7 BGE=8 BLTU=9 BGEU=10.
//    - Immediate ALU: ADDI=19 SLTI=20 SLTIU=21 XORI=22 ORI=23 ANDI=24 SLLI=25 SRLI=26 SRAI=27.
//    - Register ALU: ADD=28 SUB=29.
//  - Operand rules:
//    - I-ALU: op1=rs1, op2=imm_i. Shifts: op2 = zero-extended shamt ins[24:20], f7 must be 0000000 (SRAI 0100000).
//    - R: op1=rs1, op2=rs2.
//    - Branch: op1=rs1, op2=rs2, imm=imm_b, rd_wen=0.
//    - LUI: op1=0, op2=imm_u. AUIPC: op1=pc, op2=imm_u.
//    - JAL: op1=pc, op2=4, imm=imm_j. JALR (f3=000): op1=rs1, op2=4, imm=imm_i.
//  - rs*_addr = 0 for operands the format does not read.
//  - out_rd_wen forced 0 when rd=0.
//  - Illegal (any other opcode/f3/f7): oh=0, rd_wen=0, op1=op2=imm=0, rs*_addr=0, out_illegal=1.
//    out_valid still asserts; out_ins and out_ins_addr still pass through.
// CONFIGURATION
//  - ID_BYPASS_EN defined: wb_* ports exist.
//    When wb_wen & wb_addr!=0 & wb_addr==rs1_addr/rs2_addr, wb_data replaces rs1_data/rs2_data before the operand mux.
//  - ID_BYPASS_EN undefined: no wb_* ports; regfile data is used as-is, and the regfile must write-before-read.
// TESTING
//  1. ADDI x3,x1,-1 (0xFFF08193), rs1_data=5
//     -> next cycle out_valid=1, oh=19, op1=5, op2=0xFFFFFFFF, rd=3, rd_wen=1.
//  2. Accept SUB (0x40208133), hold out_ready=0 for 3 cycles
//     -> in_ready=0 and outputs stable; on out_ready=1, bundle consumed in one cycle.
//  3. flush=1 in the same cycle as in_valid=1 with an ADD
//     -> out_valid=0 next cycle, instruction dropped.
//  4. Opcode 0x7F word 0x0000007F
//     -> out_illegal=1, oh=0, rd_wen=0, out_valid=1.
//  5. ADDI x0,x0,1 (0x00100013) -> oh=19, rd_wen=0.
//     LUI x5,0x12345 (0x123452B7) -> op2=0x12345000, rd_wen=1.
//  6. ID_BYPASS_EN: ADD x3,x1,x2 with rs1_data=1, wb_wen=1, wb_addr=1, wb_data=9
//     -> op1=9. Same stimulus with wb_addr=0 -> op1=1.

Source files
------------

// File: rtl/id_stage.sv
//============================================================================
// Module      : id_stage
// Description : Registered RV32I decode stage. Drives register-file read
//               addresses combinationally from the incoming instruction,
//               samples the read data in the same cycle and registers the
//               decoded operands, immediate and control fields behind a
//               valid/ready handshake. Supports flush, backpressure hold
//               and illegal-instruction flagging.
// Options     : ID_BYPASS_EN - adds the wb_* writeback bypass ports that
//               override register-file read data on an address match.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module id_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int OH_W    = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_ins,
    input  logic [XLEN-1:0]    in_ins_addr,
    output logic [RADDR_W-1:0] rs1_addr,
    output logic [RADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
`ifdef ID_BYPASS_EN
    input  logic               wb_wen,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_op1,
    output logic [XLEN-1:0]    out_op2,
    output logic [XLEN-1:0]    out_imm,
    output logic [31:0]        out_ins,
    output logic [XLEN-1:0]    out_ins_addr,
    output logic [RADDR_W-1:0] out_rd_addr,
    output logic               out_rd_wen,
    output logic [OH_W-1:0]    out_oh,
    output logic               out_illegal
);

    // Major opcodes
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // Operation codes handed to ex
    localparam logic [OH_W-1:0] c_OH_LUI   = OH_W'(1);
    localparam logic [OH_W-1:0] c_OH_AUIPC = OH_W'(2);
    localparam logic [OH_W-1:0] c_OH_JAL   = OH_W'(3);
    localparam logic [OH_W-1:0] c_OH_JALR  = OH_W'(4);
    localparam logic [OH_W-1:0] c_OH_BEQ   = OH_W'(5);
    localparam logic [OH_W-1:0] c_OH_BNE   = OH_W'(6);
    localparam logic [OH_W-1:0] c_OH_BLT   = OH_W'(7);
    localparam logic [OH_W-1:0] c_OH_BGE   = OH_W'(8);
    localparam logic [OH_W-1:0] c_OH_BLTU  = OH_W'(9);
    localparam logic [OH_W-1:0] c_OH_BGEU  = OH_W'(10);
    localparam logic [OH_W-1:0] c_OH_ADDI  = OH_W'(19);
    localparam logic [OH_W-1:0] c_OH_SLTI  = OH_W'(20);
    localparam logic [OH_W-1:0] c_OH_SLTIU = OH_W'(21);
    localparam logic [OH_W-1:0] c_OH_XORI  = OH_W'(22);
    localparam logic [OH_W-1:0] c_OH_ORI   = OH_W'(23);
    localparam logic [OH_W-1:0] c_OH_ANDI  = OH_W'(24);
    localparam logic [OH_W-1:0] c_OH_SLLI  = OH_W'(25);
    localparam logic [OH_W-1:0] c_OH_SRLI  = OH_W'(26);
    localparam logic [OH_W-1:0] c_OH_SRAI  = OH_W'(27);
    localparam logic [OH_W-1:0] c_OH_ADD   = OH_W'(28);
    localparam logic [OH_W-1:0] c_OH_SUB   = OH_W'(29);

    // Operand source selects
    localparam logic [1:0] c_OP1_ZERO  = 2'd0;
    localparam logic [1:0] c_OP1_RS1   = 2'd1;
    localparam logic [1:0] c_OP1_PC    = 2'd2;

    localparam logic [2:0] c_OP2_ZERO  = 3'd0;
    localparam logic [2:0] c_OP2_RS2   = 3'd1;
    localparam logic [2:0] c_OP2_IMM   = 3'd2;
    localparam logic [2:0] c_OP2_SHAMT = 3'd3;
    localparam logic [2:0] c_OP2_FOUR  = 3'd4;

    // Instruction fields
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [2:0] w_f3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [6:0] w_f7;

    assign w_opcode = in_ins[6:0];
    assign w_rd     = in_ins[11:7];
    assign w_f3     = in_ins[14:12];
    assign w_rs1    = in_ins[19:15];
    assign w_rs2    = in_ins[24:20];
    assign w_f7     = in_ins[31:25];

    // Sign-extended immediates for each format
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_shamt;

    assign w_imm_i = XLEN'($signed(in_ins[31:20]));
    assign w_imm_b = XLEN'($signed({in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0}));
    assign w_imm_u = XLEN'($signed({in_ins[31:12], 12'b0}));
    assign w_imm_j = XLEN'($signed({in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0}));
    assign w_shamt = XLEN'(in_ins[24:20]);

    // Decode results
    logic            w_legal;
    logic [OH_W-1:0] w_oh;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic [1:0]      w_op1_sel;
    logic [2:0]      w_op2_sel;
    logic [XLEN-1:0] w_imm;
    logic            w_wen;

    // Opcode/funct decode; anything not explicitly recognised stays illegal
    // and is forced to an all-zero control bundle at the end.
    always_comb begin
        w_legal   = 1'b0;
        w_oh      = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_op1_sel = c_OP1_ZERO;
        w_op2_sel = c_OP2_ZERO;
        w_imm     = '0;
        w_wen     = 1'b0;
        case (w_opcode)
            c_OPC_LUI: begin
                w_legal   = 1'b1;
                w_oh      = c_OH_LUI;
                w_op2_sel = c_OP2_IMM;
                w_imm     = w_imm_u;
                w_wen     = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_legal   = 1'b1;
                w_oh      = c_OH_AUIPC;
                w_op1_sel = c_OP1_PC;
                w_op2_sel = c_OP2_IMM;
                w_imm     = w_imm_u;
                w_wen     = 1'b1;
            end
            c_OPC_JAL: begin
                w_legal   = 1'b1;
                w_oh      = c_OH_JAL;
                w_op1_sel = c_OP1_PC;
                w_op2_sel = c_OP2_FOUR;
                w_imm     = w_imm_j;
                w_wen     = 1'b1;
            end
            c_OPC_JALR: begin
                w_legal   = (w_f3 == 3'b000);
                w_oh      = c_OH_JALR;
                w_use_rs1 = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_FOUR;
                w_imm     = w_imm_i;
                w_wen     = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_legal   = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_RS2;
                w_imm     = w_imm_b;
                case (w_f3)
                    3'b000:  w_oh = c_OH_BEQ;
                    3'b001:  w_oh = c_OH_BNE;
                    3'b100:  w_oh = c_OH_BLT;
                    3'b101:  w_oh = c_OH_BGE;
                    3'b110:  w_oh = c_OH_BLTU;
                    3'b111:  w_oh = c_OH_BGEU;
                    default: w_legal = 1'b0;
                endcase
            end
            c_OPC_OPIMM: begin
                w_legal   = 1'b1;
                w_use_rs1 = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_IMM;
                w_imm     = w_imm_i;
                w_wen     = 1'b1;
                case (w_f3)
                    3'b000: w_oh = c_OH_ADDI;
                    3'b010: w_oh = c_OH_SLTI;
                    3'b011: w_oh = c_OH_SLTIU;
                    3'b100: w_oh = c_OH_XORI;
                    3'b110: w_oh = c_OH_ORI;
                    3'b111: w_oh = c_OH_ANDI;
                    3'b001: begin
                        w_op2_sel = c_OP2_SHAMT;
                        w_oh      = c_OH_SLLI;
                        w_legal   = (w_f7 == c_F7_ZERO);
                    end
                    default: begin
                        w_op2_sel = c_OP2_SHAMT;
                        if (w_f7 == c_F7_ZERO)
                            w_oh = c_OH_SRLI;
                        else if (w_f7 == c_F7_ALT)
                            w_oh = c_OH_SRAI;
                        else
                            w_legal = 1'b0;
                    end
                endcase
            end
            c_OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op1_sel = c_OP1_RS1;
                w_op2_sel = c_OP2_RS2;
                w_wen     = 1'b1;
                if (w_f3 == 3'b000 && w_f7 == c_F7_ZERO) begin
                    w_legal = 1'b1;
                    w_oh    = c_OH_ADD;
                end else if (w_f3 == 3'b000 && w_f7 == c_F7_ALT) begin
                    w_legal = 1'b1;
                    w_oh    = c_OH_SUB;
                end
            end
            default: w_legal = 1'b0;
        endcase

        // Illegal words carry no operands, no write and no register reads
        if (!w_legal) begin
            w_oh      = '0;
            w_use_rs1 = 1'b0;
            w_use_rs2 = 1'b0;
            w_op1_sel = c_OP1_ZERO;
            w_op2_sel = c_OP2_ZERO;
            w_imm     = '0;
            w_wen     = 1'b0;
        end
    end

    assign rs1_addr = w_use_rs1 ? RADDR_W'(w_rs1) : '0;
    assign rs2_addr = w_use_rs2 ? RADDR_W'(w_rs2) : '0;

    // Register data as seen by the operand mux
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

`ifdef ID_BYPASS_EN
    assign w_rs1_val = (wb_wen && (wb_addr != '0) && (wb_addr == rs1_addr)) ? wb_data : rs1_data;
    assign w_rs2_val = (wb_wen && (wb_addr != '0) && (wb_addr == rs2_addr)) ? wb_data : rs2_data;
`else
    assign w_rs1_val = rs1_data;
    assign w_rs2_val = rs2_data;
`endif

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // Operand multiplexers
    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        case (w_op1_sel)
            c_OP1_RS1: w_op1 = w_rs1_val;
            c_OP1_PC:  w_op1 = in_ins_addr;
            default:   w_op1 = '0;
        endcase
        case (w_op2_sel)
            c_OP2_RS2:   w_op2 = w_rs2_val;
            c_OP2_IMM:   w_op2 = w_imm;
            c_OP2_SHAMT: w_op2 = w_shamt;
            c_OP2_FOUR:  w_op2 = XLEN'(4);
            default:     w_op2 = '0;
        endcase
    end

    // Handshake: flush blocks capture for the whole cycle it is asserted
    logic r_valid;
    logic w_accept;

    assign in_ready = (!r_valid || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    logic [XLEN-1:0]    r_op1;
    logic [XLEN-1:0]    r_op2;
    logic [XLEN-1:0]    r_imm;
    logic [31:0]        r_ins;
    logic [XLEN-1:0]    r_ins_addr;
    logic [RADDR_W-1:0] r_rd_addr;
    logic               r_rd_wen;
    logic [OH_W-1:0]    r_oh;
    logic               r_illegal;

    // Pipe register: reset > flush > accept > drain; holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_imm      <= '0;
            r_ins      <= '0;
            r_ins_addr <= '0;
            r_rd_addr  <= '0;
            r_rd_wen   <= 1'b0;
            r_oh       <= '0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_imm      <= w_imm;
            r_ins      <= in_ins;
            r_ins_addr <= in_ins_addr;
            r_rd_addr  <= RADDR_W'(w_rd);
            r_rd_wen   <= w_wen && (w_rd != 5'd0);
            r_oh       <= w_oh;
            r_illegal  <= !w_legal;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_op1      = r_op1;
    assign out_op2      = r_op2;
    assign out_imm      = r_imm;
    assign out_ins      = r_ins;
    assign out_ins_addr = r_ins_addr;
    assign out_rd_addr  = r_rd_addr;
    assign out_rd_wen   = r_rd_wen;
    assign out_oh       = r_oh;
    assign out_illegal  = r_illegal;

endmodule

`default_nettype wire
